// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_pkg                                                                  |
// | Shared types and default constants for the digital clock front end.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } key_state_t;

    localparam int KEY_ALARM_ACK = 0;
    localparam int KEY_MIN       = 1;
    localparam int KEY_HOUR      = 2;
    localparam int KEY_MODE      = 3;

    // 1 ms debounce tick at a 100 MHz CP
    localparam int c_N_KEYS      = 4;
    localparam int c_TICK_DIV    = 100000;
    localparam int c_DB_TICKS    = 20;
    localparam int c_DELAY_TICKS = 500;
    localparam int c_RATE_TICKS  = 100;

endpackage
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_channel                                                                |
// | One key: synchronizer, debounce/hold state machine and repeat counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_channel
    import clock_pkg::*;
#(
    parameter int DB_TICKS    = c_DB_TICKS,
    parameter int DELAY_TICKS = c_DELAY_TICKS,
    parameter int RATE_TICKS  = c_RATE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int c_DB_W   = $clog2(DB_TICKS + 1);
    localparam int c_HOLD_W = $clog2(DELAY_TICKS + RATE_TICKS + 1);

    localparam logic [c_DB_W-1:0]   c_DB_ONE   = c_DB_W'(1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DB_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
    localparam logic [c_HOLD_W-1:0] c_DELAY    = c_HOLD_W'(DELAY_TICKS);
    localparam logic [c_HOLD_W-1:0] c_REPEAT   = c_HOLD_W'(DELAY_TICKS + RATE_TICKS);

    logic                r_meta;
    logic                r_sync;
    key_state_t          r_state;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_long;

    key_state_t          w_state_nxt;
    logic [c_DB_W-1:0]   w_db_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_HOLD_W-1:0] w_hold_inc;
    logic                w_level_nxt;
    logic                w_press_nxt;
    logic                w_release_nxt;
    logic                w_long_nxt;

    assign w_hold_inc = r_hold_cnt + c_HOLD_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_db_nxt      = r_db_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_level_nxt   = r_level;
        w_long_nxt    = r_long;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync) begin
                    w_db_nxt    = '0;
                    w_state_nxt = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!r_sync) begin
                    w_state_nxt = IDLE;
                end else if (i_tick) begin
                    if (r_db_cnt == c_DB_LAST) begin
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                        w_hold_nxt  = '0;
                        w_state_nxt = HELD;
                    end else begin
                        w_db_nxt = r_db_cnt + c_DB_ONE;
                    end
                end
            end
            HELD: begin
                if (!r_sync) begin
                    w_db_nxt    = '0;
                    w_state_nxt = DB_RELEASE;
                end else if (i_tick) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc == c_DELAY) begin
                        w_press_nxt = 1'b1;
                        w_long_nxt  = 1'b1;
                    end else if (w_hold_inc == c_REPEAT) begin
                        // Reload so later repeats recur every RATE_TICKS ticks
                        w_press_nxt = 1'b1;
                        w_hold_nxt  = c_DELAY;
                    end
                end
            end
            DB_RELEASE: begin
                if (r_sync) begin
                    w_state_nxt = HELD;
                end else if (i_tick) begin
                    if (r_db_cnt == c_DB_LAST) begin
                        w_level_nxt   = 1'b0;
                        w_long_nxt    = 1'b0;
                        w_release_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_db_nxt = r_db_cnt + c_DB_ONE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_conditioner                                                            |
// | Shared debounce-tick prescaler plus N_KEYS independent key channels.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_conditioner
    import clock_pkg::*;
#(
    parameter int N_KEYS      = c_N_KEYS,
    parameter int TICK_DIV    = c_TICK_DIV,
    parameter int DB_TICKS    = c_DB_TICKS,
    parameter int DELAY_TICKS = c_DELAY_TICKS,
    parameter int RATE_TICKS  = c_RATE_TICKS
) (
    input  logic              CP,
    input  logic              CLR,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

    logic [c_PRE_W-1:0] r_prescale;
    logic               r_tick;

    // Free-running; first tick lands TICK_DIV cycles after CLR releases
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            r_prescale <= '0;
            r_tick     <= 1'b0;
        end else if (r_prescale == c_PRE_LAST) begin
            r_prescale <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_prescale <= r_prescale + c_PRE_ONE;
            r_tick     <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_channel #(
                .DB_TICKS    (DB_TICKS),
                .DELAY_TICKS (DELAY_TICKS),
                .RATE_TICKS  (RATE_TICKS)
            ) u_channel (
                .clk       (CP),
                .rst       (CLR),
                .i_tick    (r_tick),
                .i_raw     (key_raw[gi]),
                .o_level   (key_level[gi]),
                .o_press   (key_press[gi]),
                .o_release (key_release[gi]),
                .o_long    (key_long[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_conditioner                                                         |
// | Directed and random stimulus against a tick-counting reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_key_conditioner;
    import clock_pkg::*;

    localparam int N_KEYS      = 4;
    localparam int TICK_DIV    = 4;
    localparam int DB_TICKS    = 3;
    localparam int DELAY_TICKS = 5;
    localparam int RATE_TICKS  = 2;

    logic              CP  = 1'b0;
    logic              CLR = 1'b0;
    logic [N_KEYS-1:0] key_raw = '0;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .N_KEYS      (N_KEYS),
        .TICK_DIV    (TICK_DIV),
        .DB_TICKS    (DB_TICKS),
        .DELAY_TICKS (DELAY_TICKS),
        .RATE_TICKS  (RATE_TICKS)
    ) dut (
        .CP          (CP),
        .CLR         (CLR),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 CP = ~CP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at t=%0t", name, val, lo, hi, $time);
        end
    endtask

    // Reference model: debounce = DB_TICKS ticks of an unbroken disagreement,
    // repeats derived from the total number of held ticks.
    int                m_edges = 0;
    bit [N_KEYS-1:0]   m_s1 = '0, m_s2 = '0, m_sync_now = '0;
    bit                m_tick = 1'b0, m_tick_now = 1'b0;
    bit [N_KEYS-1:0]   m_level = '0, m_press = '0, m_release = '0, m_long = '0, m_pending = '0;
    int                m_db [N_KEYS];
    int                m_held [N_KEYS];

    always @(posedge CP or posedge CLR) begin
        if (CLR) begin
            m_edges = 0; m_s1 = '0; m_s2 = '0; m_tick = 1'b0;
            m_level = '0; m_press = '0; m_release = '0; m_long = '0; m_pending = '0;
            for (int k = 0; k < N_KEYS; k++) begin
                m_db[k] = 0;
                m_held[k] = 0;
            end
        end else begin
            m_sync_now = m_s2;
            m_tick_now = m_tick;
            m_s2 = m_s1;
            m_s1 = key_raw;
            m_edges++;
            m_tick = (m_edges % TICK_DIV == 0);
            m_press = '0;
            m_release = '0;
            for (int k = 0; k < N_KEYS; k++) begin
                if (m_pending[k]) begin
                    if (m_sync_now[k] == m_level[k]) begin
                        m_pending[k] = 1'b0;
                    end else if (m_tick_now) begin
                        m_db[k]++;
                        if (m_db[k] == DB_TICKS) begin
                            m_pending[k] = 1'b0;
                            m_level[k] = m_sync_now[k];
                            if (m_sync_now[k]) begin
                                m_press[k] = 1'b1;
                                m_held[k] = 0;
                            end else begin
                                m_release[k] = 1'b1;
                                m_long[k] = 1'b0;
                            end
                        end
                    end
                end else if (m_sync_now[k] != m_level[k]) begin
                    m_pending[k] = 1'b1;
                    m_db[k] = 0;
                end else if (m_level[k] && m_tick_now) begin
                    m_held[k]++;
                    if (m_held[k] >= DELAY_TICKS) begin
                        m_long[k] = 1'b1;
                        if ((m_held[k] - DELAY_TICKS) % RATE_TICKS == 0) m_press[k] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge CP) begin
        check("key_level", 32'(key_level), 32'(m_level));
        check("key_press", 32'(key_press), 32'(m_press));
        check("key_release", 32'(key_release), 32'(m_release));
        check("key_long", 32'(key_long), 32'(m_long));
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CP);
            #1;
        end
    endtask

    task automatic wait_pulse(input int k, input bit want_release, input int max_cycles,
                              output int lat, output int presses_seen);
        lat = -1;
        presses_seen = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(posedge CP);
            #1;
            if (want_release ? key_release[k] : key_press[k]) begin
                lat = i;
                return;
            end
            if (key_press[k]) presses_seen++;
        end
    endtask

    initial begin
        int lat, other, cnt, rel;

        CLR = 1'b1;
        cycles(3);
        check("reset_outputs", 32'({key_level, key_press, key_release, key_long}), 32'd0);
        CLR = 1'b0;
        cycles(2);

        // Clean press of KEY_MIN with auto-repeat
        key_raw[KEY_MIN] = 1'b1;
        wait_pulse(KEY_MIN, 1'b0, 40, lat, other);
        check_range("press_latency", lat, 11, 15);
        check("press_level", 32'(key_level[KEY_MIN]), 32'd1);
        check("model_level_pin", 32'(m_level[KEY_MIN]), 32'd1);
        check("press_long_early", 32'(key_long[KEY_MIN]), 32'd0);
        cycles(1);
        check("press_width", 32'(key_press[KEY_MIN]), 32'd0);
        wait_pulse(KEY_MIN, 1'b0, 40, lat, other);
        check_range("first_repeat", lat + 1, 16, 24);
        check("long_after_delay", 32'(key_long[KEY_MIN]), 32'd1);
        check("model_long_pin", 32'(m_long[KEY_MIN]), 32'd1);
        for (int r = 0; r < 4; r++) begin
            wait_pulse(KEY_MIN, 1'b0, 20, lat, other);
            check("repeat_period", 32'(lat), 32'd8);
        end

        // Release straight after a repeat
        key_raw[KEY_MIN] = 1'b0;
        wait_pulse(KEY_MIN, 1'b1, 40, lat, other);
        check_range("release_latency", lat, 11, 15);
        check("release_press_free", 32'(other), 32'd0);
        check("release_level_long", 32'({key_level[KEY_MIN], key_long[KEY_MIN]}), 32'd0);
        cycles(1);
        check("release_width", 32'(key_release[KEY_MIN]), 32'd0);
        cycles(5);

        // Bouncing KEY_ALARM_ACK, then steady
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            key_raw[KEY_ALARM_ACK] = ((i / 3) % 2 == 0);
            cycles(1);
            if (key_press[KEY_ALARM_ACK]) cnt++;
        end
        check("bounce_no_press", 32'(cnt), 32'd0);
        key_raw[KEY_ALARM_ACK] = 1'b1;
        wait_pulse(KEY_ALARM_ACK, 1'b0, 40, lat, other);
        check_range("bounce_press_latency", lat, 11, 15);

        // Two-cycle release glitch while held
        cycles(3);
        key_raw[KEY_ALARM_ACK] = 1'b0;
        cycles(2);
        key_raw[KEY_ALARM_ACK] = 1'b1;
        cnt = 0;
        rel = 0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (key_press[KEY_ALARM_ACK]) cnt++;
            if (key_release[KEY_ALARM_ACK]) rel++;
        end
        check("glitch_no_release", 32'(rel), 32'd0);
        check_range("glitch_repeats", cnt, 2, 6);
        key_raw[KEY_ALARM_ACK] = 1'b0;
        wait_pulse(KEY_ALARM_ACK, 1'b1, 60, lat, other);
        check_range("glitch_release_seen", lat, 1, 60);
        cycles(4);

        // Simultaneous press of KEY_MIN and KEY_HOUR
        key_raw[KEY_HOUR:KEY_MIN] = 2'b11;
        wait_pulse(KEY_MIN, 1'b0, 40, lat, other);
        check_range("dual_latency", lat, 11, 15);
        check("dual_press", 32'(key_press[KEY_HOUR:KEY_MIN]), 32'd3);
        check("dual_level", 32'(key_level[KEY_HOUR:KEY_MIN]), 32'd3);

        // CLR mid-hold
        cycles(30);
        #1;
        CLR = 1'b1;
        #1;
        check("clr_immediate", 32'({key_level, key_press, key_release, key_long}), 32'd0);
        cycles(2);
        CLR = 1'b0;
        wait_pulse(KEY_MIN, 1'b0, 40, lat, other);
        check_range("clr_repress_latency", lat, 11, 15);
        key_raw = '0;
        cycles(20);

        // Random activity: fast toggling, then slower so repeats happen
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N_KEYS; k++)
                if ($urandom_range(0, 19) == 0) key_raw[k] = ~key_raw[k];
            cycles(1);
        end
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < N_KEYS; k++)
                if ($urandom_range(0, 59) == 0) key_raw[k] = ~key_raw[k];
            cycles(1);
        end
        key_raw = '0;
        cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
